// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for the multicycle MIPS-subset datapath with
// memory wait states, an unsupported-opcode trap and a retired-instruction counter.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    ADDIEX = 4'd10, ADDIWB = 4'd11, HALT = 4'd12
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        retire;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    PCSource = 2'b00;
    retire = 1'b0;
    state_d = state_q;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                  opcode == OP_R    ? EXEC   :
                  opcode == OP_BEQ  ? BRANCH :
                  opcode == OP_J    ? JUMP   :
                  opcode == OP_ADDI ? ADDIEX : HALT;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = state_q == ADDIEX ? ADDIWB : opcode == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        retire = mem_ready;
        state_d = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        retire = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        retire = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
        retire = 1'b1;
        state_d = FETCH;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        retire = 1'b1;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
    count_d = count_q + 32'(retire);
  end
  assign state = state_q;
  assign halted = state_q == HALT;
  assign instr_count = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; each cycle pushes the expected state,
// control word and count, then pops and compares against the DUT mid-cycle.
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic halted;
  logic [31:0] instr_count;
  int checks = 0, failures = 0;
  logic [31:0] cnt = 0;
  typedef struct { logic [3:0] st; logic [15:0] ctl; logic [31:0] count; } exp_t;
  exp_t sb[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  wire [15:0] ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Expected control word straight from the per-state output table
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic r);
    logic pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sb_ = 0, op = 0, ps = 0;
    case (s)
      4'd0: begin mr = 1; sb_ = 2'b01; irw = r; pw = r; end
      4'd1: sb_ = 2'b11;
      4'd2, 4'd10: begin sa = 1; sb_ = 2'b10; end
      4'd3: begin mr = 1; iord = 1; end
      4'd4: begin m2r = 1; rw = 1; end
      4'd5: begin mw = 1; iord = 1; end
      4'd6: begin sa = 1; op = 2'b10; end
      4'd7: begin rd = 1; rw = 1; end
      4'd8: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9: begin pw = 1; ps = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb_, op, ps};
  endfunction

  task automatic cyc(input logic [3:0] es, input logic rdy);
    exp_t e;
    @(negedge clk);
    mem_ready = rdy;
    sb.push_back('{es, exp_ctl(es, rdy), cnt});
    #1;
    e = sb.pop_front();
    checks++;
    if (state !== e.st) begin failures++; $display("FAIL state: got %0d want %0d", state, e.st); end
    checks++;
    if (ctl !== e.ctl) begin failures++; $display("FAIL ctl st%0d: got %h want %h", e.st, ctl, e.ctl); end
    checks++;
    if (instr_count !== e.count) begin failures++; $display("FAIL count st%0d: got %0d want %0d", e.st, instr_count, e.count); end
    checks++;
    if (halted !== (e.st == 4'd12)) begin failures++; $display("FAIL halted st%0d: got %b", e.st, halted); end
  endtask

  task automatic release_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    cnt = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (state !== 4'd0 || instr_count !== 0 || halted !== 1'b0) begin
      failures++; $display("FAIL reset_state: got st=%0d cnt=%0d h=%b want 0 0 0", state, instr_count, halted);
    end
    checks++;
    if (ctl !== exp_ctl(4'd0, 1'b0)) begin failures++; $display("FAIL reset_ctl: got %h want %h", ctl, exp_ctl(4'd0, 1'b0)); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({IRWrite, PCWrite} !== 2'b11) begin failures++; $display("FAIL reset_mealy: got %b want 11", {IRWrite, PCWrite}); end
    release_reset();
  endtask

  task automatic test_lw();
    opcode = 6'b100011;
    cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(3, 1); cyc(4, 1); cnt++;
  endtask

  task automatic test_back_to_back();
    opcode = 6'b000000; cyc(0, 1); cyc(1, 1); cyc(6, 1); cyc(7, 1); cnt++;
    opcode = 6'b101011; cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(5, 1); cnt++;
    opcode = 6'b000100; cyc(0, 1); cyc(1, 1); cyc(8, 1); cnt++;
    opcode = 6'b000010; cyc(0, 1); cyc(1, 1); cyc(9, 1); cnt++;
    opcode = 6'b001000; cyc(0, 1); cyc(1, 1); cyc(10, 1); cyc(11, 1); cnt++;
  endtask

  task automatic test_fetch_wait();
    opcode = 6'b000000;
    cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 1); cyc(1, 0); cyc(6, 0); cyc(7, 0); cnt++;
  endtask

  task automatic test_sw_wait();
    opcode = 6'b101011;
    cyc(0, 1); cyc(1, 0); cyc(2, 0); cyc(5, 0); cyc(5, 0); cyc(5, 1); cnt++;
    cyc(0, 0);
  endtask

  task automatic test_halt();
    opcode = 6'b111111;
    cyc(0, 1); cyc(1, 1);
    for (int i = 0; i < 20; i++) cyc(12, 1'($urandom_range(0, 1)));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || instr_count !== 0 || halted !== 1'b0) begin
      failures++; $display("FAIL halt_reset: got st=%0d cnt=%0d h=%b want 0 0 0", state, instr_count, halted);
    end
    release_reset();
  endtask

  task automatic test_reset_memrd();
    opcode = 6'b100011;
    cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(3, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || instr_count !== 0 || RegWrite !== 1'b0) begin
      failures++; $display("FAIL memrd_abort: got st=%0d cnt=%0d rw=%b want 0 0 0", state, instr_count, RegWrite);
    end
    release_reset();
    cyc(0, 0); cyc(0, 1); cyc(1, 1);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_fetch_wait();
    test_sw_wait();
    test_halt();
    test_lw();
    test_reset_memrd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS-subset datapath: a Moore-style FSM that breaks each instruction into fetch, decode, execute, memory and write-back steps. It drives the mux selects, register and memory enables and ALU operation class of a shared-memory multicycle datapath (PC, IR, A/B, ALUOut, MDR registers) in place of the single-cycle combinational decoder. It adds memory wait states via a ready handshake, traps on unsupported opcodes and counts retired instructions.

## Interface

- No parameters.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified externally by ALU zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  IR load.
- MemtoReg  output  1  write-back select: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  destination select: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = PC, 1 = A.
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = use funct.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding (debug).
- halted  output  1  FSM is in HALT.
- instr_count  output  32  retired-instruction counter.

## Operation

- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12. Codes 13–15 are unreachable and go to HALT.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Outputs are per state; anything not listed is 0:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready (the only Mealy terms).
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: MemtoReg=1, RegDst=0, RegWrite=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - HALT: all controls 0, halted=1.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay in FETCH.
  - DECODE→ by opcode: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX, any other→HALT.
  - MEMADR→MEMRD (lw) or MEMWR (sw), using the current opcode.
  - MEMRD→MEMWB when mem_ready, else stay.
  - MEMWR→FETCH when mem_ready, else stay.
  - EXEC→RWB; ADDIEX→ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP→FETCH.
  - HALT→HALT until reset.
- Retire: instr_count increments by 1 in MEMWB, RWB, ADDIWB, BRANCH, JUMP, and in MEMWR on the cycle mem_ready=1. The counter wraps 0xFFFFFFFF→0. The branch retires whether taken or not.
- Request outputs are held stable throughout a wait: MemRead, MemWrite and IorD stay constant while mem_ready=0.

## Timing

- Reset (reset=0): state=FETCH asynchronously, instr_count=0, halted=0. Outputs take FETCH values immediately, with IRWrite/PCWrite following mem_ready.
- First fetch occurs on the first rising edge after reset deasserts.
- Latency with mem_ready tied to 1:
  - lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
  - Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction aborts it: no retire, and the counter clears.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- instr_count updates on the same edge that leaves the retiring state.

## Test plan

- Reset then lw with mem_ready=1: state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4; instr_count=1.
- R-type, sw, beq, j, addi back-to-back with mem_ready=1: 4+4+3+3+4=18 cycles, instr_count=5, each state's outputs match the listed set exactly.
- FETCH with mem_ready low for 3 cycles: state stays 0 with IRWrite=PCWrite=0 and MemRead=1 throughout; IRWrite=PCWrite=1 in the 4th cycle, then DECODE.
- sw with mem_ready=0 for 2 cycles in MEMWR: MemWrite=1 and IorD=1 held for 3 cycles; instr_count increments only on the ready cycle.
- Opcode 111111 at DECODE: HALT, halted=1, all controls 0, instr_count frozen for 20 cycles. reset=0 then returns to FETCH with count 0.
- reset pulsed low during MEMRD: state=0 asynchronously (before the next clock edge), instr_count=0, no RegWrite pulse.
